// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: Moore control FSM for a multicycle MIPS datapath.
// Sequences FETCH/DECODE/execute states, raises datapath strobes and mux
// selects per state, and aborts memory states that wait too long on mem_ready.
// Optional feature: define JUMP_INSTR_EN to decode the J instruction; without
// it opcode 000010 is illegal and code 11 behaves like any unused code.
module mips_multicycle_control #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       i_or_d,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [1:0] alu_ctrl,
    output logic [3:0] state,
    output logic       illegal,
    output logic       timeout
);

    localparam logic [3:0] FETCH   = 4'd0;
    localparam logic [3:0] DECODE  = 4'd1;
    localparam logic [3:0] MEMADR  = 4'd2;
    localparam logic [3:0] MEMRD   = 4'd3;
    localparam logic [3:0] MEMWB   = 4'd4;
    localparam logic [3:0] MEMWR   = 4'd5;
    localparam logic [3:0] EXECUTE = 4'd6;
    localparam logic [3:0] ALUWB   = 4'd7;
    localparam logic [3:0] BRANCH  = 4'd8;
    localparam logic [3:0] ADDIEX  = 4'd9;
    localparam logic [3:0] ADDIWB  = 4'd10;
`ifdef JUMP_INSTR_EN
    localparam logic [3:0] JUMP    = 4'd11;
    localparam logic [5:0] OP_J    = 6'b000010;
`endif

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic [7:0] wait_cnt;
    logic       wait_state;
    logic       expired;
    logic       illegal_d;

    assign state = state_q;

    // Detect a memory wait that has run out of budget this cycle.
    always_comb begin
        wait_state = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
        expired    = wait_state && !mem_ready && (wait_cnt == TIMEOUT_LIM);
    end

    // Next-state selection; unknown opcodes and unused codes fall back to FETCH.
    always_comb begin
        state_d   = FETCH;
        illegal_d = 1'b0;
        case (state_q)
            FETCH:   state_d = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
`ifdef JUMP_INSTR_EN
                    OP_J:         state_d = JUMP;
`endif
                    default:      illegal_d = 1'b1;
                endcase
            end
            MEMADR: begin
                case (opcode)
                    OP_LW:   state_d = MEMRD;
                    OP_SW:   state_d = MEMWR;
                    default: illegal_d = 1'b1;
                endcase
            end
            MEMRD:   state_d = mem_ready ? MEMWB : MEMRD;
            MEMWB:   state_d = FETCH;
            MEMWR:   state_d = mem_ready ? FETCH : MEMWR;
            EXECUTE: state_d = ALUWB;
            ALUWB:   state_d = FETCH;
            BRANCH:  state_d = FETCH;
            ADDIEX:  state_d = ADDIWB;
            ADDIWB:  state_d = FETCH;
`ifdef JUMP_INSTR_EN
            JUMP:    state_d = FETCH;
`endif
            default: illegal_d = 1'b1;
        endcase
        if (expired) begin
            state_d = FETCH;
        end
    end

    // State, wait counter and event pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FETCH;
            wait_cnt <= '0;
            illegal  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state_q <= state_d;
            illegal <= illegal_d;
            timeout <= expired;
            // A FETCH->FETCH abort is not a state change, so clear on expiry too.
            if ((state_d != state_q) || expired) begin
                wait_cnt <= '0;
            end else if (wait_state && !mem_ready) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    // Moore outputs per state; reset and an expiring wait suppress all strobes.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        i_or_d        = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_source     = 2'b00;
        alu_ctrl      = 2'b00;
        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            DECODE:  alu_src_b = 2'b11;
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            EXECUTE: begin
                alu_src_a = 1'b1;
                alu_ctrl  = 2'b10;
            end
            ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_ctrl      = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            ADDIWB:  reg_write = 1'b1;
`ifdef JUMP_INSTR_EN
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
`endif
            default: ;
        endcase
        if (rst || expired) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            ir_write      = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            reg_write     = 1'b0;
        end
        if (rst) begin
            i_or_d     = 1'b0;
            mem_to_reg = 1'b0;
            reg_dst    = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b01;
            pc_source  = 2'b00;
            alu_ctrl   = 2'b00;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control: directed instruction sequences for the
// multicycle control FSM; expected outputs are queued per cycle and checked
// by an independent monitor on the falling clock edge.
module tb_mips_multicycle_control;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;
`ifdef JUMP_INSTR_EN
    localparam logic J_ILL = 1'b0;
`else
    localparam logic J_ILL = 1'b1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = OP_R;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write;
    logic       i_or_d, mem_to_reg, reg_dst, alu_src_a;
    logic [1:0] alu_src_b, pc_source, alu_ctrl;
    logic [3:0] state;
    logic       illegal, timeout;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string       name;
        logic [21:0] v;
    } exp_t;
    exp_t sb[$];

    mips_multicycle_control #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .i_or_d(i_or_d), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
        .alu_ctrl(alu_ctrl), .state(state), .illegal(illegal), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Expected output word for a hand-chosen state; order matches the monitor.
    function automatic logic [21:0] build(input logic [3:0] st, input logic r, input logic mr,
                                          input logic expc, input logic ill, input logic to);
        logic pw, pwc, irw, mrd, mwr, rw, iod, m2r, rdst, asa;
        logic [1:0] asb, psrc, actl;
        {pw, pwc, irw, mrd, mwr, rw, iod, m2r, rdst, asa} = '0;
        asb = 2'b00; psrc = 2'b00; actl = 2'b00;
        case (st)
            4'd0:  begin mrd = 1'b1; asb = 2'b01; pw = mr; irw = mr; end
            4'd1:  asb = 2'b11;
            4'd2:  begin asa = 1'b1; asb = 2'b10; end
            4'd3:  begin mrd = 1'b1; iod = 1'b1; end
            4'd4:  begin rw = 1'b1; m2r = 1'b1; end
            4'd5:  begin mwr = 1'b1; iod = 1'b1; end
            4'd6:  begin asa = 1'b1; actl = 2'b10; end
            4'd7:  begin rw = 1'b1; rdst = 1'b1; end
            4'd8:  begin asa = 1'b1; actl = 2'b01; pwc = 1'b1; psrc = 2'b01; end
            4'd9:  begin asa = 1'b1; asb = 2'b10; end
            4'd10: rw = 1'b1;
`ifdef JUMP_INSTR_EN
            4'd11: begin pw = 1'b1; psrc = 2'b10; end
`endif
            default: ;
        endcase
        if (r || expc) {pw, pwc, irw, mrd, mwr, rw} = '0;
        if (r) begin
            {iod, m2r, rdst, asa} = '0;
            asb = 2'b01; psrc = 2'b00; actl = 2'b00;
        end
        return {st, pw, pwc, irw, mrd, mwr, rw, iod, m2r, rdst, asa, asb, psrc, actl, ill, to};
    endfunction

    // Drive one cycle of inputs and queue what the DUT must show during it.
    task automatic step(input string nm, input logic r, input logic mr, input logic [5:0] op,
                        input logic [3:0] st, input logic ill, input logic to, input logic expc);
        exp_t e;
        rst = r;
        mem_ready = mr;
        opcode = op;
        e.name = nm;
        e.v = build(st, r, mr, expc, ill, to);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every queued expectation against the live outputs.
    initial begin
        exp_t e;
        logic [21:0] act;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                act = {state, pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write,
                       i_or_d, mem_to_reg, reg_dst, alu_src_a, alu_src_b, pc_source, alu_ctrl,
                       illegal, timeout};
                vectors++;
                if (act !== e.v) begin
                    miscompares++;
                    $display("FAIL %s: got %b, want %b (state,pw,pwc,irw,mrd,mwr,rw,iod,m2r,rdst,asa,asb,psrc,actl,ill,to)",
                             e.name, act, e.v);
                end
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        step("rst_hold", 1, 1, OP_R, 4'd0, 0, 0, 0);

        step("lw_fetch",  0, 1, OP_LW, 4'd0, 0, 0, 0);
        step("lw_decode", 0, 1, OP_LW, 4'd1, 0, 0, 0);
        step("lw_memadr", 0, 1, OP_LW, 4'd2, 0, 0, 0);
        step("lw_memrd",  0, 1, OP_LW, 4'd3, 0, 0, 0);
        step("lw_memwb",  0, 1, OP_LW, 4'd4, 0, 0, 0);

        step("sw_fetch",  0, 1, OP_SW, 4'd0, 0, 0, 0);
        step("sw_decode", 0, 1, OP_SW, 4'd1, 0, 0, 0);
        step("sw_memadr", 0, 1, OP_SW, 4'd2, 0, 0, 0);
        step("sw_memwr",  0, 1, OP_SW, 4'd5, 0, 0, 0);

        step("r_fetch",   0, 1, OP_R, 4'd0, 0, 0, 0);
        step("r_decode",  0, 1, OP_R, 4'd1, 0, 0, 0);
        step("r_execute", 0, 1, OP_R, 4'd6, 0, 0, 0);
        step("r_aluwb",   0, 1, OP_R, 4'd7, 0, 0, 0);

        step("addi_fetch",  0, 1, OP_ADDI, 4'd0, 0, 0, 0);
        step("addi_decode", 0, 1, OP_ADDI, 4'd1, 0, 0, 0);
        step("addi_ex",     0, 1, OP_ADDI, 4'd9, 0, 0, 0);
        step("addi_wb",     0, 1, OP_ADDI, 4'd10, 0, 0, 0);

        step("beq_fetch",  0, 1, OP_BEQ, 4'd0, 0, 0, 0);
        step("beq_decode", 0, 1, OP_BEQ, 4'd1, 0, 0, 0);
        step("beq_branch", 0, 1, OP_BEQ, 4'd8, 0, 0, 0);

        step("j_fetch",  0, 1, OP_J, 4'd0, 0, 0, 0);
        step("j_decode", 0, 1, OP_J, 4'd1, 0, 0, 0);
`ifdef JUMP_INSTR_EN
        step("j_jump",   0, 1, OP_J, 4'd11, 0, 0, 0);
`endif

        step("bad_fetch",  0, 1, OP_BAD, 4'd0, J_ILL, 0, 0);
        step("bad_decode", 0, 1, OP_BAD, 4'd1, 0, 0, 0);
        step("bad_pulse",  0, 1, OP_SW,  4'd0, 1, 0, 0);

        step("swt_decode", 0, 1, OP_SW, 4'd1, 0, 0, 0);
        step("swt_memadr", 0, 1, OP_SW, 4'd2, 0, 0, 0);
        for (int i = 0; i < 15; i++) step("swt_wait", 0, 0, OP_SW, 4'd5, 0, 0, 0);
        step("swt_expire",  0, 0, OP_SW, 4'd5, 0, 0, 1);
        step("swt_tofetch", 0, 0, OP_SW, 4'd0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step("swt_fetchwait", 0, 0, OP_SW, 4'd0, 0, 0, 0);

        step("lwr_fetch",  0, 1, OP_LW, 4'd0, 0, 0, 0);
        step("lwr_decode", 0, 1, OP_LW, 4'd1, 0, 0, 0);
        step("lwr_memadr", 0, 1, OP_LW, 4'd2, 0, 0, 0);
        for (int i = 0; i < 15; i++) step("lwr_wait", 0, 0, OP_LW, 4'd3, 0, 0, 0);
        step("lwr_win",   0, 1, OP_LW, 4'd3, 0, 0, 0);
        step("lwr_memwb", 0, 1, OP_LW, 4'd4, 0, 0, 0);

        for (int i = 0; i < 15; i++) step("ft_wait", 0, 0, OP_LW, 4'd0, 0, 0, 0);
        step("ft_expire", 0, 0, OP_LW, 4'd0, 0, 0, 1);
        step("ft_to",     0, 1, OP_LW, 4'd0, 0, 1, 0);

        step("rst_decode",   0, 1, OP_LW, 4'd1, 0, 0, 0);
        step("rst_memadr",   0, 1, OP_LW, 4'd2, 0, 0, 0);
        step("rst_memrd_w",  0, 0, OP_LW, 4'd3, 0, 0, 0);
        step("rst_in_memrd", 1, 0, OP_LW, 4'd3, 0, 0, 0);
        step("rst_held",     1, 1, OP_LW, 4'd0, 0, 0, 0);
        step("rst_resume",   0, 1, OP_BEQ, 4'd0, 0, 0, 0);
        step("rst_decode2",  0, 1, OP_BEQ, 4'd1, 0, 0, 0);
        step("rst_branch2",  0, 1, OP_BEQ, 4'd8, 0, 0, 0);
        step("final_fetch",  0, 0, OP_BEQ, 4'd0, 0, 0, 0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_control.md
MIPS_MULTICYCLE_CONTROL -- requirements
Module: mips_multicycle_control

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, max consecutive cycles waiting on mem_ready before a memory state aborts; legal range 1..255.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 opcode  input  6  instruction[31:26], sampled in DECODE and MEMADR.
REQ-006 mem_ready  input  1  memory access completes this cycle.
REQ-007 pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write  output  1 each  datapath strobes.
REQ-008 i_or_d, mem_to_reg, reg_dst, alu_src_a  output  1 each  datapath mux selects.
REQ-009 alu_src_b, pc_source  output  2 each  mux selects.
REQ-010 alu_ctrl  output  2  to ALU control: 00 add, 01 sub, 10 decode funct, 11 never driven.
REQ-011 state  output  4  current state code (debug).
REQ-012 illegal, timeout  output  1 each  registered one-cycle event pulses.

Function
REQ-013 The block SHALL be a Moore FSM with codes FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11; codes 12-15 SHALL go to FETCH next cycle with illegal=1.
REQ-014 Opcodes: R=000000, LW=100011, SW=101011, BEQ=000100, ADDI=001000, J=000010.
REQ-015 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_ctrl=00, pc_source=00; ir_write=pc_write=mem_ready; advance to DECODE only when mem_ready=1.
REQ-016 DECODE: alu_src_a=0, alu_src_b=11, alu_ctrl=00; next: LW/SW->MEMADR, R->EXECUTE, BEQ->BRANCH, ADDI->ADDIEX, J->JUMP, other->FETCH with illegal pulsed the following cycle.
REQ-017 MEMADR: alu_src_a=1, alu_src_b=10, alu_ctrl=00; LW->MEMRD, SW->MEMWR.
REQ-018 MEMRD: mem_read=1, i_or_d=1; ->MEMWB on mem_ready. MEMWR: mem_write=1, i_or_d=1; ->FETCH on mem_ready.
REQ-019 MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1; ->FETCH.
REQ-020 EXECUTE: alu_src_a=1, alu_src_b=00, alu_ctrl=10; ->ALUWB. ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0; ->FETCH.
REQ-021 BRANCH: alu_src_a=1, alu_src_b=00, alu_ctrl=01, pc_write_cond=1, pc_source=01; ->FETCH.
REQ-022 ADDIEX: alu_src_a=1, alu_src_b=10, alu_ctrl=00; ->ADDIWB. ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0; ->FETCH.
REQ-023 JUMP: pc_write=1, pc_source=10; ->FETCH.
REQ-024 Any signal not listed for a state SHALL be 0.
REQ-025 An 8-bit wait counter SHALL increment each cycle in FETCH/MEMRD/MEMWR with mem_ready=0, clear on any state change; when it equals MEM_TIMEOUT with mem_ready=0, next state SHALL be FETCH, timeout pulses next cycle, no strobe asserted that cycle.
REQ-026 mem_ready=1 in the timeout cycle SHALL win: normal transition, no timeout.
REQ-027 Instruction latencies (cycles, zero wait): LW 5, SW 4, R 4, ADDI 4, BEQ 3, J 3.

Reset
REQ-028 rst=1 SHALL load state=FETCH, wait counter=0, illegal=0, timeout=0 at the next edge.
REQ-029 While rst=1 all strobes of REQ-007 SHALL be forced 0 regardless of state; selects follow FETCH values.
REQ-030 rst mid-instruction SHALL abandon it with no further writes.

Configuration
REQ-031 Macro JUMP_INSTR_EN: defined -> J decoded per REQ-016/023; undefined -> JUMP state absent, opcode 000010 treated as illegal (->FETCH, illegal pulse), code 11 handled per REQ-013.

Verification
REQ-032 LW, mem_ready=1 always -> states 0,1,2,3,4,0; reg_write=1 only in cycle 5, mem_to_reg=1.
REQ-033 BEQ -> states 0,1,8,0; alu_ctrl=01, pc_write_cond=1, pc_source=01 in state 8.
REQ-034 opcode=111111 in DECODE -> next state 0, illegal=1 exactly one cycle, no strobe asserted.
REQ-035 SW with mem_ready low 20 cycles in MEMWR, MEM_TIMEOUT=15 -> state 0 after 15 wait cycles, timeout=1 one cycle, mem_write never combined with mem_ready=1.
REQ-036 rst=1 during MEMRD -> next state 0, all strobes 0 while rst high, FETCH resumes after release.
REQ-037 J with and without JUMP_INSTR_EN -> 0,1,11,0 with pc_write=1, pc_source=10; versus 0,1,0 with illegal pulse.
